// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin N-host to M-device bus with address decode; define BUS_TIMEOUT_EN for the response watchdog with device quarantine
module bus_rr_arbiter #(
  parameter int unsigned NrHosts       = 2,
  parameter int unsigned NrDevices     = 8,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NrHosts-1:0]        host_req_i,
  output logic [NrHosts-1:0]        host_gnt_o,
  input  logic [AddressWidth-1:0]   host_addr_i [NrHosts],
  input  logic [NrHosts-1:0]        host_we_i,
  input  logic [DataWidth/8-1:0]    host_be_i [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]        host_rvalid_o,
  output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
  output logic [NrHosts-1:0]        host_err_o,
  output logic [NrDevices-1:0]      device_req_o,
  output logic [AddressWidth-1:0]   device_addr_o [NrDevices],
  output logic [NrDevices-1:0]      device_we_o,
  output logic [DataWidth/8-1:0]    device_be_o [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
  input  logic [NrDevices-1:0]      device_rvalid_i,
  input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
  input  logic [NrDevices-1:0]      device_err_i,
  input  logic [AddressWidth-1:0]   cfg_device_addr_base_i [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask_i [NrDevices],
  output logic                      timeout_o
);
  localparam int unsigned HW = NrHosts > 1 ? $clog2(NrHosts) : 1;
  localparam int unsigned DW = NrDevices > 1 ? $clog2(NrDevices) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_e;
  state_e state_q, state_d;
  logic [HW-1:0] ptr_q, ptr_d, host_q, host_d, win;
  logic [DW-1:0] dev_q, dev_d, hit_dev;
  logic [NrDevices-1:0] quar;
  logic any_req, hit, go, fwd, rsp, err_st, expire;
  // nearest requester after the pointer wins; loop runs far-to-near so the nearest assignment lands last
  always_comb begin
    any_req = 1'b0;
    win = ptr_q;
    for (int i = NrHosts; i >= 1; i--) begin
      if (host_req_i[(int'(ptr_q) + i) % NrHosts]) begin
        any_req = 1'b1;
        win = HW'((int'(ptr_q) + i) % NrHosts);
      end
    end
  end
  // address decode of the winning host; lowest matching device index wins
  always_comb begin
    hit = 1'b0;
    hit_dev = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((host_addr_i[win] & cfg_device_addr_mask_i[d]) == cfg_device_addr_base_i[d]) begin
        hit = 1'b1;
        hit_dev = DW'(d);
      end
    end
  end
  // every event is gated by rst_ni so nothing leaks out while reset is asserted
  assign go     = rst_ni && state_q == IDLE && any_req;
  assign fwd    = go && hit && !quar[hit_dev];
  assign rsp    = rst_ni && state_q == WAIT && device_rvalid_i[dev_q];
  assign err_st = rst_ni && state_q == ERR;
  // next-state: grant moves to WAIT or ERR, any completion returns to IDLE
  always_comb begin
    state_d = go ? (fwd ? WAIT : ERR) : (err_st || rsp || expire) ? IDLE : state_q;
    ptr_d   = go ? win : ptr_q;
    host_d  = go ? win : host_q;
    dev_d   = go ? hit_dev : dev_q;
  end
  // state register; pointer parks on the last host so host 0 is first after reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= HW'(NrHosts - 1);
      host_q  <= '0;
      dev_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      host_q  <= host_d;
      dev_q   <= dev_d;
    end
  end
  // outputs: grant and device request are combinational from the request in IDLE
  always_comb begin
    host_gnt_o = '0;
    host_rvalid_o = '0;
    host_err_o = '0;
    device_req_o = '0;
    for (int h = 0; h < NrHosts; h++) host_rdata_o[h] = '0;
    host_gnt_o[win] = go;
    device_req_o[hit_dev] = fwd;
    host_rvalid_o[host_q] = rsp || err_st || expire;
    host_err_o[host_q] = (rsp && device_err_i[dev_q]) || err_st || expire;
    host_rdata_o[host_q] = rsp ? device_rdata_i[dev_q] : '0;
  end
  // forwarded fields are broadcast; only the requested device looks at them
  always_comb begin
    device_we_o = {NrDevices{host_we_i[win]}};
    for (int d = 0; d < NrDevices; d++) begin
      device_addr_o[d]  = host_addr_i[win];
      device_be_o[d]    = host_be_i[win];
      device_wdata_o[d] = host_wdata_i[win];
    end
  end
`ifdef BUS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [NrDevices-1:0] quar_q, quar_d;
  assign quar      = quar_q;
  assign expire    = rst_ni && state_q == WAIT && !device_rvalid_i[dev_q] && cnt_q == 16'(TimeoutCycles - 1);
  assign timeout_o = expire;
  // watchdog counts WAIT cycles; a late response from a quarantined device releases it
  always_comb begin
    cnt_d = state_q == WAIT ? cnt_q + 16'd1 : '0;
    quar_d = quar_q & ~device_rvalid_i;
    if (expire) quar_d[dev_q] = 1'b1;
  end
  // watchdog and quarantine registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      quar_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      quar_q <= quar_d;
    end
  end
`else
  assign quar      = '0;
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif
endmodule
